axi_aw_w_scheduler: RTL
=======================

Name: axi_aw_w_scheduler

Overview:
- Control-only AXI write-path scheduler that shares one master AW/W port among NumReq requesters (I$, bypass, D$ in the cache subsystem).
- Grants AW round-robin and records each granted requester index in an in-order grant queue.
- Steers W beats from the queue head until the beat carrying w_last.
- Payload muxing is done externally, driven by aw_sel_o and w_sel_o.

Parameters:
- NumReq, 3, number of requesters (≥2).
- Depth, 4, max write transactions accepted on AW whose final W beat has not yet been sent (power of 2, ≥2).
- IdxW, $clog2(NumReq), derived: width of the requester index.
- CntW, $clog2(Depth+1), derived: width of the outstanding counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- stall_i  in  1  block new AW grants (an already-presented AW is not withdrawn)
- req_aw_valid_i  in  NumReq  per-requester AW valid
- req_aw_ready_o  out  NumReq  per-requester AW ready
- req_w_valid_i  in  NumReq  per-requester W valid
- req_w_last_i  in  NumReq  per-requester W last
- req_w_ready_o  out  NumReq  per-requester W ready
- aw_valid_o  out  1  master AW valid
- aw_ready_i  in  1  master AW ready
- aw_sel_o  out  IdxW  requester whose AW payload drives the master
- w_valid_o  out  1  master W valid
- w_last_o  out  1  master W last
- w_ready_i  in  1  master W ready
- w_sel_o  out  IdxW  requester whose W payload drives the master (queue head)
- outstanding_o  out  CntW  queue occupancy
- busy_o  out  1  outstanding_o != 0 or AW held

Behaviour:
- Reset (rst_i high at a clock edge): queue emptied, AW FSM to IDLE, round-robin pointer = 0.
- Reset values: aw_valid_o=0, aw_sel_o=0, w_valid_o=0, w_last_o=0, w_sel_o=0, outstanding_o=0, busy_o=0, all ready outputs 0. Reset mid-burst drops all state with no completion.
- AW FSM, IDLE:
  - If any req_aw_valid_i is set, !stall_i and outstanding_o < Depth, pick the first valid index scanning from the pointer upward, modulo NumReq.
  - Drive aw_valid_o=1 and aw_sel_o=index combinationally in the same cycle.
  - If aw_ready_i=1: handshake; req_aw_ready_o[index]=aw_ready_i; stay in IDLE.
  - Otherwise latch the index and go to HOLD.
- AW FSM, HOLD:
  - aw_valid_o=1 with the latched aw_sel_o, regardless of stall_i, fullness or other requesters (AXI stability).
  - On aw_ready_i: handshake, return to IDLE.
- On every AW handshake: push the index into the queue and set pointer = (index+1) mod NumReq. req_aw_ready_o is 0 for all non-selected requesters.
- Full: when outstanding_o==Depth, aw_valid_o=0 in IDLE. HOLD is never entered when full, so no push ever occurs while full.
- W path:
  - Queue head becomes visible the cycle after its AW push; no same-cycle fall-through.
  - When not empty: w_sel_o=head, w_valid_o=req_w_valid_i[head], w_last_o=req_w_last_i[head], req_w_ready_o[head]=w_ready_i; all other W readies are 0.
  - Empty: w_valid_o=0 and all W readies are 0.
  - Pop when w_valid_o & w_ready_i & w_last_o.
- Push and pop in the same cycle: occupancy unchanged; read/write pointers wrap modulo Depth.
- outstanding_o counts +1 on push only, −1 on pop only, unchanged on both.
- Requesters may drive W before their AW is granted; such beats stall (ready=0) until their entry reaches the head.

Test Plan:
- After reset, all three AW valid with aw_ready_i=1 → grants in order 0,1,2,0 on consecutive cycles; outstanding_o increments to 4, then aw_valid_o=0 (full).
- Requester 1 AW with aw_ready_i held 0 for 3 cycles and requester 0 raised in cycle 2 → aw_sel_o stays 1 for 4 cycles; grant to 1 on the ready cycle; requester 0 is granted next.
- AW grants 2 then 0; requester 0 W valid first → req_w_ready_o[0]=0 until requester 2's 4-beat burst finishes with last; then w_sel_o=0; outstanding 2→1→0.
- Occupancy 2, AW handshake and W last handshake in the same cycle → outstanding_o stays 2; head advances by one.
- stall_i=1 in IDLE with valid requests → aw_valid_o=0. stall_i=1 while in HOLD → aw_valid_o remains 1 until the handshake.
- rst_i asserted mid-burst with occupancy 3 → next cycle all outputs at reset values; first grant after reset is the lowest valid index from pointer 0.

Source files
------------

// File: rtl/axi_aw_w_scheduler.sv
// rtl/axi_aw_w_scheduler.sv - round-robin AW arbiter with in-order W steering for a shared write port
//
// Control-only scheduler: arbitrates NumReq requesters onto one master AW
// channel, remembers every granted index in an in-order grant queue, and
// steers W beats from the queue head until its last beat is accepted.
// Payload muxing happens outside, keyed on aw_sel_o / w_sel_o.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   stall_i               blocks new AW grants (a held AW stays presented)
//   req_aw_valid_i/ready_o  per-requester AW handshake
//   req_w_valid_i/last_i/ready_o  per-requester W handshake
//   aw_valid_o/ready_i/sel_o  master AW handshake and payload select
//   w_valid_o/last_o/ready_i/sel_o  master W handshake and payload select
//   outstanding_o         grant queue occupancy
//   busy_o                queue not empty or an AW is being held

module axi_aw_w_scheduler #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned Depth  = 4,
  localparam int unsigned IdxW  = $clog2(NumReq),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic [NumReq-1:0] req_aw_valid_i,
  output logic [NumReq-1:0] req_aw_ready_o,
  input  logic [NumReq-1:0] req_w_valid_i,
  input  logic [NumReq-1:0] req_w_last_i,
  output logic [NumReq-1:0] req_w_ready_o,
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output logic [IdxW-1:0]   aw_sel_o,
  output logic              w_valid_o,
  output logic              w_last_o,
  input  logic              w_ready_i,
  output logic [IdxW-1:0]   w_sel_o,
  output logic [CntW-1:0]   outstanding_o,
  output logic              busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } aw_state_e;

  aw_state_e       state_q, state_d;
  logic [IdxW-1:0] hold_idx_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic            push, pop;
  logic            full, empty;
  logic [IdxW-1:0] head;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin : p_pick
    int unsigned cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (int'(rr_ptr_q) + i) % NumReq;
      if (!pick_found && req_aw_valid_i[IdxW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  // AW FSM: IDLE presents a fresh pick; HOLD keeps the presented AW stable
  // until accepted, ignoring stall, fullness and later arrivals.
  always_comb begin
    state_d        = state_q;
    aw_valid_o     = 1'b0;
    aw_sel_o       = '0;
    req_aw_ready_o = '0;
    push           = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (pick_found && !stall_i && !full) begin
            aw_valid_o = 1'b1;
            aw_sel_o   = pick_idx;
            if (aw_ready_i) begin
              req_aw_ready_o[pick_idx] = 1'b1;
              push = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          aw_valid_o = 1'b1;
          aw_sel_o   = hold_idx_q;
          if (aw_ready_i) begin
            req_aw_ready_o[hold_idx_q] = 1'b1;
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // W steering from the queue head; only the head requester may see ready.
  always_comb begin
    w_sel_o       = '0;
    w_valid_o     = 1'b0;
    w_last_o      = 1'b0;
    req_w_ready_o = '0;
    if (!rst_i && !empty) begin
      w_sel_o             = head;
      w_valid_o           = req_w_valid_i[head];
      w_last_o            = req_w_last_i[head];
      req_w_ready_o[head] = w_ready_i;
    end
  end

  assign pop           = w_valid_o & w_ready_i & w_last_o;
  assign outstanding_o = rst_i ? '0 : count_q;
  assign busy_o        = !rst_i && (!empty || state_q == HOLD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hold_idx_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) hold_idx_q <= pick_idx;
      if (push) begin
        mem_q[wr_ptr_q] <= aw_sel_o;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
        rr_ptr_q        <= (aw_sel_o == LastIdx) ? '0 : aw_sel_o + IdxW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

endmodule
